idecode_queue: RTL and testbench

Buffered, parametrised instruction-decode stage for the Ch0re pipeline. Sits between fetch and execute. Accepts fetched instructions into a DEPTH-entry FIFO and decodes the head entry with the existing combinational `idecoder`. Presents the decoded fields from an output register with a valid/ready handshake. Adds flush, occupancy reporting, and a halt-on-illegal-instruction state that the bare decoder lacks.

---
 rtl/idecode_queue_pkg.sv | 71 +++++++
 rtl/idecoder_intf.sv | 23 ++
 rtl/idecode_queue_idecoder.sv | 139 +++++++++++++
 rtl/idecode_queue.sv | 156 +++++++++++++++
 tb/tb_idecode_queue.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/idecode_queue_pkg.sv
// Shared types for the Ch0re decode stage: instruction formats, ALU controls,
// decode-queue state and the RV64I opcode map.
package idecode_queue_pkg;

  typedef enum logic [2:0] {
    IFORMAT_R = 3'd0,
    IFORMAT_I = 3'd1,
    IFORMAT_S = 3'd2,
    IFORMAT_B = 3'd3,
    IFORMAT_U = 3'd4,
    IFORMAT_J = 3'd5
  } instr_format_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    ALU_MUX1_RS1  = 2'd0,
    ALU_MUX1_PC   = 2'd1,
    ALU_MUX1_ZERO = 2'd2
  } alu_mux1_sel_t;

  typedef enum logic [1:0] {
    ALU_MUX2_RS2  = 2'd0,
    ALU_MUX2_IMM  = 2'd1,
    ALU_MUX2_FOUR = 2'd2
  } alu_mux2_sel_t;

  typedef enum logic {
    IDQ_RUN  = 1'b0,
    IDQ_HALT = 1'b1
  } idq_state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // alt selects the funct7[5] variant (SUB / SRA)
  function automatic alu_op_t alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
    alu_op_t op;
    case (funct3)
      3'd0:    op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      3'd7:    op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idecoder_intf.sv
// Bundle between the decode queue and the combinational instruction decoder.
interface idecoder_intf
  import idecode_queue_pkg::*;
#(
  parameter int XLEN = 64
) ();
  logic [31:0]     instr;
  logic [4:0]      rf_raddr1;
  logic [4:0]      rf_raddr2;
  logic [4:0]      rf_waddr;
  instr_format_t   instr_format;
  alu_op_t         alu_op;
  logic [XLEN-1:0] imm;
  alu_mux1_sel_t   alu_mux1_sel;
  alu_mux2_sel_t   alu_mux2_sel;
  logic            illegal_instr;

  modport dec (
    input  instr,
    output rf_raddr1, rf_raddr2, rf_waddr, instr_format, alu_op, imm,
           alu_mux1_sel, alu_mux2_sel, illegal_instr
  );
endinterface

// File: rtl/idecode_queue_idecoder.sv
// Combinational RV64I base decoder: register addresses, format, ALU controls,
// sign-extended immediate and an illegal-encoding flag.
module idecoder
  import idecode_queue_pkg::*;
#(
  parameter int XLEN = 64
) (
  idecoder_intf.dec dec
);

  logic [31:0]     instr_s;
  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [6:0]      funct7_s;
  logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [4:0]      raddr1_s, raddr2_s, waddr_s;
  instr_format_t   format_s;
  alu_op_t         alu_op_s;
  logic [XLEN-1:0] imm_s;
  alu_mux1_sel_t   mux1_s;
  alu_mux2_sel_t   mux2_s;
  logic            illegal_s;

  assign instr_s  = dec.instr;
  assign opcode_s = instr_s[6:0];
  assign funct3_s = instr_s[14:12];
  assign funct7_s = instr_s[31:25];

  assign imm_i_s = {{(XLEN-12){instr_s[31]}}, instr_s[31:20]};
  assign imm_s_s = {{(XLEN-12){instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
  assign imm_b_s = {{(XLEN-13){instr_s[31]}}, instr_s[31], instr_s[7], instr_s[30:25], instr_s[11:8], 1'b0};
  assign imm_u_s = {{(XLEN-32){instr_s[31]}}, instr_s[31:12], 12'h000};
  assign imm_j_s = {{(XLEN-21){instr_s[31]}}, instr_s[31], instr_s[19:12], instr_s[20], instr_s[30:21], 1'b0};

  // Field decode; addresses a format does not use are forced to x0
  always_comb begin
    raddr1_s  = instr_s[19:15];
    raddr2_s  = instr_s[24:20];
    waddr_s   = instr_s[11:7];
    format_s  = IFORMAT_R;
    alu_op_s  = ALU_ADD;
    imm_s     = {XLEN{1'b0}};
    mux1_s    = ALU_MUX1_RS1;
    mux2_s    = ALU_MUX2_RS2;
    illegal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (funct7_s == 7'b0000000) begin
          alu_op_s = alu_op_from_funct3(funct3_s, 1'b0);
        end else if (funct7_s == 7'b0100000 && (funct3_s == 3'd0 || funct3_s == 3'd5)) begin
          alu_op_s = alu_op_from_funct3(funct3_s, 1'b1);
        end else begin
          illegal_s = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        format_s = IFORMAT_I;
        raddr2_s = 5'd0;
        imm_s    = imm_i_s;
        mux2_s   = ALU_MUX2_IMM;
        if (funct3_s == 3'd1) begin
          alu_op_s  = ALU_SLL;
          illegal_s = (instr_s[31:26] != 6'b000000);
        end else if (funct3_s == 3'd5) begin
          alu_op_s  = instr_s[30] ? ALU_SRA : ALU_SRL;
          illegal_s = (instr_s[31:26] != 6'b000000) && (instr_s[31:26] != 6'b010000);
        end else begin
          alu_op_s = alu_op_from_funct3(funct3_s, 1'b0);
        end
      end
      OPC_LOAD: begin
        format_s  = IFORMAT_I;
        raddr2_s  = 5'd0;
        imm_s     = imm_i_s;
        mux2_s    = ALU_MUX2_IMM;
        illegal_s = (funct3_s == 3'd7);
      end
      OPC_STORE: begin
        format_s  = IFORMAT_S;
        waddr_s   = 5'd0;
        imm_s     = imm_s_s;
        mux2_s    = ALU_MUX2_IMM;
        illegal_s = funct3_s[2];
      end
      OPC_BRANCH: begin
        format_s = IFORMAT_B;
        waddr_s  = 5'd0;
        imm_s    = imm_b_s;
        case (funct3_s)
          3'd0, 3'd1: alu_op_s = ALU_SUB;
          3'd4, 3'd5: alu_op_s = ALU_SLT;
          3'd6, 3'd7: alu_op_s = ALU_SLTU;
          default:    illegal_s = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        format_s = IFORMAT_U;
        raddr1_s = 5'd0;
        raddr2_s = 5'd0;
        imm_s    = imm_u_s;
        mux1_s   = (opcode_s == OPC_LUI) ? ALU_MUX1_ZERO : ALU_MUX1_PC;
        mux2_s   = ALU_MUX2_IMM;
      end
      OPC_JAL: begin
        format_s = IFORMAT_J;
        raddr1_s = 5'd0;
        raddr2_s = 5'd0;
        imm_s    = imm_j_s;
        mux1_s   = ALU_MUX1_PC;
        mux2_s   = ALU_MUX2_FOUR;
      end
      OPC_JALR: begin
        format_s  = IFORMAT_I;
        raddr2_s  = 5'd0;
        imm_s     = imm_i_s;
        mux1_s    = ALU_MUX1_PC;
        mux2_s    = ALU_MUX2_FOUR;
        illegal_s = (funct3_s != 3'd0);
      end
      default: begin
        raddr1_s  = 5'd0;
        raddr2_s  = 5'd0;
        waddr_s   = 5'd0;
        illegal_s = 1'b1;
      end
    endcase
  end

  assign dec.rf_raddr1     = raddr1_s;
  assign dec.rf_raddr2     = raddr2_s;
  assign dec.rf_waddr      = waddr_s;
  assign dec.instr_format  = format_s;
  assign dec.alu_op        = alu_op_s;
  assign dec.imm           = imm_s;
  assign dec.alu_mux1_sel  = mux1_s;
  assign dec.alu_mux2_sel  = mux2_s;
  assign dec.illegal_instr = illegal_s;

endmodule

// File: rtl/idecode_queue.sv
// Buffered decode stage: fetch FIFO, head-of-queue decode, registered output
// with valid/ready, flush, and halt after issuing an illegal instruction.
module idecode_queue
  import idecode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_fetch_valid,
  output logic                     o_fetch_ready,
  input  logic [31:0]              i_fetch_instr,
  input  logic [XLEN-1:0]          i_fetch_pc,
  output logic                     o_dec_valid,
  input  logic                     i_dec_ready,
  output logic [XLEN-1:0]          o_pc,
  output logic [4:0]               o_rf_raddr1,
  output logic [4:0]               o_rf_raddr2,
  output logic [4:0]               o_rf_waddr,
  output instr_format_t            o_instr_format,
  output alu_op_t                  o_alu_op,
  output logic [XLEN-1:0]          o_imm,
  output alu_mux1_sel_t            o_alu_mux1_sel,
  output alu_mux2_sel_t            o_alu_mux2_sel,
  output logic                     o_illegal_instr,
  output logic                     o_halted,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]     instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [PW-1:0]   wptr_r, rptr_r;
  logic [CW-1:0]   count_r;
  idq_state_t      state_r, state_next_s;
  logic            push_s, load_s, fetch_ready_s;

  logic            dec_valid_r;
  logic [XLEN-1:0] pc_r;
  logic [4:0]      raddr1_r, raddr2_r, waddr_r;
  instr_format_t   format_r;
  alu_op_t         alu_op_r;
  logic [XLEN-1:0] imm_r;
  alu_mux1_sel_t   mux1_r;
  alu_mux2_sel_t   mux2_r;
  logic            illegal_r;

  idecoder_intf #(.XLEN(XLEN)) dec_if ();
  idecoder #(.XLEN(XLEN)) u_idecoder (.dec(dec_if.dec));

  assign dec_if.instr  = instr_mem_r[rptr_r];
  assign fetch_ready_s = (count_r < CW'(DEPTH));
  assign push_s = i_fetch_valid && fetch_ready_s && !i_flush;
  assign load_s = (count_r != {CW{1'b0}}) && (state_r == IDQ_RUN) &&
                  (!dec_valid_r || i_dec_ready) && !i_flush;

  // FIFO storage write
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      instr_mem_r[wptr_r] <= i_fetch_instr;
      pc_mem_r[wptr_r]    <= i_fetch_pc;
    end
  end

  // Pointers and occupancy; flush overrides any same-cycle push or pop
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wptr_r  <= {PW{1'b0}};
      rptr_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) wptr_r <= wptr_r + PW'(1);
      if (load_s) rptr_r <= rptr_r + PW'(1);
      case ({push_s, load_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Run/halt state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_r <= IDQ_RUN;
    else       state_r <= state_next_s;
  end

  // Next state: halt once an illegal word has been captured for issue
  always_comb begin
    state_next_s = state_r;
    if (i_flush) begin
      state_next_s = IDQ_RUN;
    end else begin
      case (state_r)
        IDQ_RUN:  state_next_s = (load_s && dec_if.illegal_instr) ? IDQ_HALT : IDQ_RUN;
        IDQ_HALT: state_next_s = IDQ_HALT;
        default:  state_next_s = IDQ_RUN;
      endcase
    end
  end

  // Output register; data fields are left untouched by flush
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dec_valid_r <= 1'b0;
      pc_r        <= {XLEN{1'b0}};
      raddr1_r    <= 5'd0;
      raddr2_r    <= 5'd0;
      waddr_r     <= 5'd0;
      format_r    <= IFORMAT_R;
      alu_op_r    <= ALU_ADD;
      imm_r       <= {XLEN{1'b0}};
      mux1_r      <= ALU_MUX1_RS1;
      mux2_r      <= ALU_MUX2_RS2;
      illegal_r   <= 1'b0;
    end else if (i_flush) begin
      dec_valid_r <= 1'b0;
    end else if (load_s) begin
      dec_valid_r <= 1'b1;
      pc_r        <= pc_mem_r[rptr_r];
      raddr1_r    <= dec_if.rf_raddr1;
      raddr2_r    <= dec_if.rf_raddr2;
      waddr_r     <= dec_if.rf_waddr;
      format_r    <= dec_if.instr_format;
      alu_op_r    <= dec_if.alu_op;
      imm_r       <= dec_if.imm;
      mux1_r      <= dec_if.alu_mux1_sel;
      mux2_r      <= dec_if.alu_mux2_sel;
      illegal_r   <= dec_if.illegal_instr;
    end else if (i_dec_ready) begin
      dec_valid_r <= 1'b0;
    end else begin
      dec_valid_r <= dec_valid_r;
    end
  end

  assign o_fetch_ready   = fetch_ready_s;
  assign o_count         = count_r;
  assign o_halted        = (state_r == IDQ_HALT);
  assign o_dec_valid     = dec_valid_r;
  assign o_pc            = pc_r;
  assign o_rf_raddr1     = raddr1_r;
  assign o_rf_raddr2     = raddr2_r;
  assign o_rf_waddr      = waddr_r;
  assign o_instr_format  = format_r;
  assign o_alu_op        = alu_op_r;
  assign o_imm           = imm_r;
  assign o_alu_mux1_sel  = mux1_r;
  assign o_alu_mux2_sel  = mux2_r;
  assign o_illegal_instr = illegal_r;

endmodule

// File: tb/tb_idecode_queue.sv
// Directed + randomized bench for idecode_queue against a queue-based reference model.
module tb_idecode_queue;
  import idecode_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_flush = 1'b0;
  logic            i_fetch_valid = 1'b0;
  logic            o_fetch_ready;
  logic [31:0]     i_fetch_instr = 32'h0;
  logic [XLEN-1:0] i_fetch_pc = 64'h0;
  logic            o_dec_valid;
  logic            i_dec_ready = 1'b0;
  logic [XLEN-1:0] o_pc;
  logic [4:0]      o_rf_raddr1, o_rf_raddr2, o_rf_waddr;
  instr_format_t   o_instr_format;
  alu_op_t         o_alu_op;
  logic [XLEN-1:0] o_imm;
  alu_mux1_sel_t   o_alu_mux1_sel;
  alu_mux2_sel_t   o_alu_mux2_sel;
  logic            o_illegal_instr;
  logic            o_halted;
  logic [2:0]      o_count;

  always #5 i_clk = ~i_clk;

  idecode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_fetch_valid(i_fetch_valid), .o_fetch_ready(o_fetch_ready),
    .i_fetch_instr(i_fetch_instr), .i_fetch_pc(i_fetch_pc),
    .o_dec_valid(o_dec_valid), .i_dec_ready(i_dec_ready), .o_pc(o_pc),
    .o_rf_raddr1(o_rf_raddr1), .o_rf_raddr2(o_rf_raddr2), .o_rf_waddr(o_rf_waddr),
    .o_instr_format(o_instr_format), .o_alu_op(o_alu_op), .o_imm(o_imm),
    .o_alu_mux1_sel(o_alu_mux1_sel), .o_alu_mux2_sel(o_alu_mux2_sel),
    .o_illegal_instr(o_illegal_instr), .o_halted(o_halted), .o_count(o_count)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  ent_t fifo_q[$];
  bit   m_valid = 1'b0;
  bit   m_halted = 1'b0;
  ent_t m_out;

  function automatic bit ref_illegal(input logic [31:0] w);
    bit is_add, is_addi;
    is_add  = (w[6:0] == 7'h33) && (w[14:12] == 3'd0) && (w[31:25] == 7'h00);
    is_addi = (w[6:0] == 7'h13) && (w[14:12] == 3'd0);
    return !(is_add || is_addi);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs now applied.
  task automatic model_edge();
    bit   can_push, take;
    ent_t e;
    if (i_rst || i_flush) begin
      fifo_q.delete();
      m_valid  = 1'b0;
      m_halted = 1'b0;
      return;
    end
    can_push = fifo_q.size() < DEPTH;
    take     = fifo_q.size() > 0 && !m_halted && (!m_valid || i_dec_ready);
    if (take) begin
      m_out   = fifo_q.pop_front();
      m_valid = 1'b1;
      if (ref_illegal(m_out.instr)) m_halted = 1'b1;
    end else if (i_dec_ready) begin
      m_valid = 1'b0;
    end
    if (i_fetch_valid && can_push) begin
      e.instr = i_fetch_instr;
      e.pc    = i_fetch_pc;
      fifo_q.push_back(e);
    end
  endtask

  task automatic compare_model();
    longint exp_imm;
    chk("count", 64'(o_count), 64'(fifo_q.size()));
    chk("fetch_ready", 64'(o_fetch_ready), 64'(fifo_q.size() < DEPTH));
    chk("dec_valid", 64'(o_dec_valid), 64'(m_valid));
    chk("halted", 64'(o_halted), 64'(m_halted));
    if (m_valid) begin
      chk("pc", o_pc, m_out.pc);
      chk("illegal", 64'(o_illegal_instr), 64'(ref_illegal(m_out.instr)));
      if (!ref_illegal(m_out.instr)) begin
        chk("raddr1", 64'(o_rf_raddr1), 64'((m_out.instr >> 15) & 32'd31));
        chk("waddr", 64'(o_rf_waddr), 64'((m_out.instr >> 7) & 32'd31));
        chk("alu_op", 64'(o_alu_op), 64'(ALU_ADD));
        if (m_out.instr[6:0] == 7'h33) begin
          chk("raddr2", 64'(o_rf_raddr2), 64'((m_out.instr >> 20) & 32'd31));
          chk("format_r", 64'(o_instr_format), 64'(IFORMAT_R));
          chk("mux2_rs2", 64'(o_alu_mux2_sel), 64'(ALU_MUX2_RS2));
        end else begin
          exp_imm = longint'($signed(m_out.instr) >>> 20);
          chk("imm", o_imm, 64'(exp_imm));
          chk("format_i", 64'(o_instr_format), 64'(IFORMAT_I));
          chk("mux2_imm", 64'(o_alu_mux2_sel), 64'(ALU_MUX2_IMM));
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge i_clk);
    #1;
    compare_model();
  endtask

  task automatic push(input logic [31:0] w, input logic [63:0] pc);
    i_fetch_valid = 1'b1;
    i_fetch_instr = w;
    i_fetch_pc    = pc;
    tick();
    i_fetch_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 64'(o_dec_valid), 64'd0);
    chk({tag, "_count"}, 64'(o_count), 64'd0);
    chk({tag, "_ready"}, 64'(o_fetch_ready), 64'd1);
    chk({tag, "_halted"}, 64'(o_halted), 64'd0);
    chk({tag, "_pc"}, o_pc, 64'd0);
    chk({tag, "_imm"}, o_imm, 64'd0);
    chk({tag, "_illegal"}, 64'(o_illegal_instr), 64'd0);
    chk({tag, "_waddr"}, 64'(o_rf_waddr), 64'd0);
    chk({tag, "_raddr1"}, 64'(o_rf_raddr1), 64'd0);
  endtask

  initial begin
    int   n_out;
    bit   saw_illegal;
    int   pushed, cyc;
    int   got_q[$];
    logic [31:0] words [12];
    logic [11:0] imm12;
    logic [4:0]  rs1;

    // Reset
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;
    check_reset_values("reset");

    // Single R-type, one edge after acceptance
    i_dec_ready = 1'b1;
    push(32'h001101B3, 64'h1000);
    tick();
    chk("rtype_valid", 64'(o_dec_valid), 64'd1);
    chk("rtype_raddr1", 64'(o_rf_raddr1), 64'd2);
    chk("rtype_raddr2", 64'(o_rf_raddr2), 64'd1);
    chk("rtype_waddr", 64'(o_rf_waddr), 64'd3);
    chk("rtype_format", 64'(o_instr_format), 64'(IFORMAT_R));
    chk("rtype_pc", o_pc, 64'h1000);
    tick();

    // Fill under backpressure
    i_dec_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(32'h00310193, 64'h2000 + 64'(4 * k));
    chk("fill_count", 64'(o_count), 64'd4);
    chk("fill_ready", 64'(o_fetch_ready), 64'd0);
    chk("fill_head_pc", o_pc, 64'h2000);
    i_dec_ready = 1'b1;
    n_out = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_dec_valid) n_out++;
      tick();
    end
    chk("fill_results", 64'(n_out), 64'd5);

    // Illegal instruction halts the queue
    push(32'h001101B3, 64'h3000);
    push(32'h00000000, 64'h3004);
    push(32'h00310193, 64'h3008);
    saw_illegal = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (o_dec_valid && o_illegal_instr && o_halted) saw_illegal = 1'b1;
      tick();
    end
    chk("illegal_seen", 64'(saw_illegal), 64'd1);
    chk("halt_halted", 64'(o_halted), 64'd1);
    chk("halt_count", 64'(o_count), 64'd1);
    chk("halt_valid", 64'(o_dec_valid), 64'd0);

    // Flush beats a same-cycle push and consume
    i_flush = 1'b1;
    push(32'h00510213, 64'h4000);
    i_flush = 1'b0;
    chk("flush_count", 64'(o_count), 64'd0);
    chk("flush_valid", 64'(o_dec_valid), 64'd0);
    chk("flush_halted", 64'(o_halted), 64'd0);
    tick();
    chk("flush_lost", 64'(o_count), 64'd0);

    // Wrap-around stream with random backpressure
    for (int k = 0; k < 12; k++) begin
      imm12 = 12'($urandom);
      rs1   = 5'($urandom_range(1, 31));
      words[k] = {imm12, rs1, 3'b000, 5'(k + 1), 7'h13};
    end
    pushed = 0;
    cyc = 0;
    while (got_q.size() < 12 && cyc < 400) begin
      i_fetch_valid = (pushed < 12) && ($urandom_range(0, 3) != 0);
      i_fetch_instr = words[pushed < 12 ? pushed : 11];
      i_fetch_pc    = 64'h5000 + 64'(4 * pushed);
      i_dec_ready   = 1'($urandom_range(0, 1));
      if (o_dec_valid && i_dec_ready) got_q.push_back(int'(o_rf_waddr));
      if (i_fetch_valid && fifo_q.size() < DEPTH) pushed++;
      tick();
      cyc++;
    end
    i_fetch_valid = 1'b0;
    chk("wrap_total", 64'(got_q.size()), 64'd12);
    for (int k = 0; k < got_q.size(); k++) chk("wrap_order", 64'(got_q[k]), 64'(k + 1));

    // Reset with a full FIFO and a valid output
    i_dec_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(32'h00310193, 64'h6000 + 64'(4 * k));
    chk("pre_rst_valid", 64'(o_dec_valid), 64'd1);
    chk("pre_rst_count", 64'(o_count), 64'd4);
    i_rst = 1'b1;
    push(32'h001101B3, 64'h7000);
    i_rst = 1'b0;
    check_reset_values("midrst");
    i_dec_ready = 1'b1;
    push(32'h001101B3, 64'h7000);
    tick();
    chk("post_rst_valid", 64'(o_dec_valid), 64'd1);
    chk("post_rst_raddr1", 64'(o_rf_raddr1), 64'd2);
    chk("post_rst_waddr", 64'(o_rf_waddr), 64'd3);
    chk("post_rst_pc", o_pc, 64'h7000);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
